// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg - parametrised UART receiver.
//
// Receives frames made of a start bit, DATA_BITS data bits (LSB first), an
// optional parity bit and STOP_BITS stop bits. The bit timer restarts on
// every start edge. Each bit is the majority of three samples taken around
// mid-bit. Finished frames go to a valid/ready output register.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active high
//   rx_pin       asynchronous serial input, idle high
//   rx_data      received data, valid while rx_valid=1
//   rx_valid     a frame is held in the output register
//   rx_ready     consumer accepts when rx_valid & rx_ready
//   parity_err   parity mismatch for the frame in rx_data
//   frame_err    a stop bit was sampled low for the frame in rx_data
//   overrun_err  one-cycle pulse: a completed frame was dropped
//   busy         receiver is inside a frame
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID       = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] MID_M1    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] MID_P1    = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 sync1;
    logic                 rxs;
    logic                 armed;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic                 v0;
    logic                 v1;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_int;
    logic                 frame_err_int;

    logic                 sample_pt;
    logic                 wrap;
    logic                 voted;
    logic                 start_edge;
    logic                 frame_done;
    logic                 frame_err_final;
    logic                 parity_exp;

    always_comb begin
        sample_pt       = (cnt == MID_P1);
        wrap            = (cnt == LAST);
        voted           = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
        // armed is only set after rxs was seen high in IDLE, so a line held
        // low after a frame or break cannot retrigger.
        start_edge      = (state == IDLE) && armed && !rxs;
        frame_done      = (state == STOP) && sample_pt && (bit_idx == LAST_STOP);
        frame_err_final = frame_err_int | ~voted;
        parity_exp      = ^shreg;
        if (PARITY_MODE == 2) begin
            parity_exp = ~parity_exp;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_next = START;
                end
            end
            START: begin
                if (sample_pt && voted) begin
                    state_next = IDLE;
                end else if (wrap) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (wrap && (bit_idx == LAST_DATA)) begin
                    if (PARITY_MODE == 0) begin
                        state_next = STOP;
                    end else begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (wrap) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leave at the final stop bit's resolution point so a start
                // edge in the remaining half bit is still caught.
                if (frame_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sync1         <= 1'b1;
            rxs           <= 1'b1;
            armed         <= 1'b0;
            cnt           <= '0;
            bit_idx       <= '0;
            v0            <= 1'b0;
            v1            <= 1'b0;
            shreg         <= '0;
            par_err_int   <= 1'b0;
            frame_err_int <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            sync1 <= rx_pin;
            rxs   <= sync1;
            state <= state_next;
            armed <= (state == IDLE) && rxs;

            if (state == IDLE) begin
                cnt <= '0;
            end else if (wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (cnt == MID_M1) begin
                v0 <= rxs;
            end
            if (cnt == MID) begin
                v1 <= rxs;
            end

            if (state_next != state) begin
                bit_idx <= '0;
            end else if (wrap && ((state == DATA) || (state == STOP))) begin
                bit_idx <= bit_idx + 4'd1;
            end

            if ((state == DATA) && sample_pt) begin
                shreg <= {voted, shreg[DATA_BITS-1:1]};
            end

            if (start_edge) begin
                par_err_int   <= 1'b0;
                frame_err_int <= 1'b0;
            end
            if ((state == PARITY) && sample_pt) begin
                par_err_int <= (voted != parity_exp);
            end
            if ((state == STOP) && sample_pt && !voted) begin
                frame_err_int <= 1'b1;
            end

            overrun_err <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    parity_err <= par_err_int;
                    frame_err  <= frame_err_final;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg - bench for uart_rx_cfg with three configurations:
//   inst 0: 16 clk/bit, 8 data, even parity, 1 stop
//   inst 1: 16 clk/bit, 8 data, odd parity,  1 stop
//   inst 2: 10 clk/bit, 9 data, even parity, 2 stop
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rxp;
    logic [2:0] rdy;
    logic [2:0] vld;
    logic [2:0] pe;
    logic [2:0] fe;
    logic [2:0] ov;
    logic [2:0] bsy;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [8:0] d2;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .rx_pin(rxp[0]), .rx_data(d0), .rx_valid(vld[0]),
        .rx_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]),
        .overrun_err(ov[0]), .busy(bsy[0]));

    uart_rx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .rx_pin(rxp[1]), .rx_data(d1), .rx_valid(vld[1]),
        .rx_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]),
        .overrun_err(ov[1]), .busy(bsy[1]));

    uart_rx_cfg #(.CLKS_PER_BIT(10), .DATA_BITS(9), .PARITY_MODE(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .rx_pin(rxp[2]), .rx_data(d2), .rx_valid(vld[2]),
        .rx_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]),
        .overrun_err(ov[2]), .busy(bsy[2]));

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int errors = 0;
    int checks = 0;
    int ovr_cnt[3] = '{0, 0, 0};
    int rmode[3]   = '{1, 1, 1};  // 0 = ready low, 1 = ready high, 2 = random

    function automatic int cpb(input int i);
        return (i == 2) ? 10 : 16;
    endfunction

    function automatic int dbits(input int i);
        return (i == 2) ? 9 : 8;
    endfunction

    function automatic int pmode(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int sbits(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic logic [8:0] dat(input int i);
        case (i)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            default: return d2;
        endcase
    endfunction

    function automatic void push(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic exp_t pop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Reference: data masked to width, parity judged by counting ones over
    // data plus parity bit, frame error if any checked stop bit is low.
    function automatic exp_t model(input int i, input logic [8:0] data,
                                   input logic pbit, input logic [1:0] stops);
        exp_t e;
        int   ones;
        e.data = data & 9'((1 << dbits(i)) - 1);
        ones   = $countones(e.data) + int'(pbit);
        if (pmode(i) == 1)      e.perr = (ones % 2) != 0;
        else if (pmode(i) == 2) e.perr = (ones % 2) == 0;
        else                    e.perr = 1'b0;
        e.ferr = 1'b0;
        for (int s = 0; s < sbits(i); s++) begin
            if (!stops[s]) e.ferr = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input int i, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, i, act, exp, $time);
        end
    endtask

    // Drives one frame on instance i. spike_bit >= 0 flips the line for one
    // cycle at the centre sample of that data bit.
    task automatic send_frame(input int i, input logic [8:0] data, input logic pbit,
                              input logic [1:0] stops, input int spike_bit,
                              input int gap_bits, input bit expect_out);
        logic bits[$];
        if (expect_out) push(i, model(i, data, pbit, stops));
        bits.push_back(1'b0);
        for (int b = 0; b < dbits(i); b++) bits.push_back(data[b]);
        if (pmode(i) != 0) bits.push_back(pbit);
        for (int s = 0; s < sbits(i); s++) bits.push_back(stops[s]);
        for (int n = 0; n < bits.size(); n++) begin
            for (int c = 0; c < cpb(i); c++) begin
                @(negedge clk);
                rxp[i] = bits[n];
                if ((n == spike_bit + 1) && (c == cpb(i) / 2 + 1)) rxp[i] = ~bits[n];
                if ((n == 0) && (c == cpb(i) - 1)) check(i, "busy_in_frame", 32'(bsy[i]), 1);
            end
        end
        for (int c = 0; c < gap_bits * cpb(i); c++) begin
            @(negedge clk);
            rxp[i] = 1'b1;
        end
    endtask

    task automatic wait_drain(input int i);
        for (int c = 0; (c < 300) && (qsize(i) != 0); c++) @(negedge clk);
        check(i, "frames_pending", 32'(qsize(i)), 0);
    endtask

    // Ready changes just after the rising edge so the monitor sees the same
    // value the DUT will sample on the next edge.
    initial begin
        rdy = '1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (rmode[i] == 2) rdy[i] = 1'($urandom_range(0, 1));
                else               rdy[i] = (rmode[i] == 1);
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted frame.
    logic [2:0] pv;
    logic [2:0] pacc;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (rst) begin
            pv   = '0;
            pacc = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pacc[i])    check(i, "valid_drop", 32'(vld[i]), 0);
                else if (pv[i]) check(i, "valid_hold", 32'(vld[i]), 1);
                if (vld[i] && rdy[i]) begin
                    if (qsize(i) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame[%0d]: got data %0h expected no frame", i, dat(i));
                    end else begin
                        mon_e = pop(i);
                        check(i, "rx_data",    32'(dat(i)), 32'(mon_e.data));
                        check(i, "parity_err", 32'(pe[i]),  32'(mon_e.perr));
                        check(i, "frame_err",  32'(fe[i]),  32'(mon_e.ferr));
                    end
                end
                if (ov[i]) ovr_cnt[i]++;
                pv[i]   = vld[i];
                pacc[i] = vld[i] & rdy[i];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          base;
        logic [8:0]  data;
        logic        pbit;
        logic [1:0]  stops;
        int          spike;
        int          gap;
        logic [15:0] part;

        rst = 1'b1;
        rxp = '1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check(i, "rst_valid",   32'(vld[i]), 0);
            check(i, "rst_data",    32'(dat(i)), 0);
            check(i, "rst_perr",    32'(pe[i]),  0);
            check(i, "rst_ferr",    32'(fe[i]),  0);
            check(i, "rst_overrun", 32'(ov[i]),  0);
            check(i, "rst_busy",    32'(bsy[i]), 0);
        end
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Basic frames and parity handling.
        send_frame(0, 9'h0A5, 1'b0, 2'b11, -1, 1, 1'b1);
        send_frame(0, 9'h03C, 1'b1, 2'b11, -1, 1, 1'b1);
        send_frame(1, 9'h03C, 1'b1, 2'b11, -1, 1, 1'b1);
        wait_drain(0);
        wait_drain(1);

        // Low stop bit, then a 20-bit break.
        send_frame(0, 9'h055, 1'b0, 2'b00, -1, 2, 1'b1);
        push(0, model(0, 9'h000, 1'b0, 2'b00));
        for (int c = 0; c < 20 * 16; c++) begin
            @(negedge clk);
            rxp[0] = 1'b0;
        end
        check(0, "break_no_retrigger", 32'(bsy[0]), 0);
        for (int c = 0; c < 2 * 16; c++) begin
            @(negedge clk);
            rxp[0] = 1'b1;
        end
        wait_drain(0);

        // Short idle glitch, then a one-cycle spike inside data bit 3.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rxp[0] = 1'b0;
        end
        for (int c = 0; c < 2 * 16; c++) begin
            @(negedge clk);
            rxp[0] = 1'b1;
        end
        check(0, "glitch_false_start", 32'(bsy[0]), 0);
        send_frame(0, 9'h000, 1'b0, 2'b11, 3, 1, 1'b1);
        wait_drain(0);

        // Overrun: consumer stalled, two back-to-back frames.
        rmode[0] = 0;
        repeat (2) @(negedge clk);
        base = ovr_cnt[0];
        send_frame(0, 9'h011, 1'b0, 2'b11, -1, 0, 1'b1);
        send_frame(0, 9'h022, 1'b0, 2'b11, -1, 1, 1'b0);
        check(0, "ovr_valid_held", 32'(vld[0]), 1);
        check(0, "ovr_data_kept",  32'(d0), 32'h11);
        check(0, "ovr_pulses",     32'(ovr_cnt[0] - base), 1);
        rmode[0] = 1;
        wait_drain(0);

        // Randomised frames with a randomly stalling consumer.
        for (int i = 0; i < 3; i++) begin
            rmode[i] = 2;
            for (int n = 0; n < 15; n++) begin
                data  = 9'($urandom);
                pbit  = 1'($urandom_range(0, 1));
                stops = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
                spike = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, dbits(i) - 1)) : -1;
                gap   = (model(i, data, pbit, stops).ferr) ? 1 : int'($urandom_range(0, 2));
                send_frame(i, data, pbit, stops, spike, gap, 1'b1);
            end
            rmode[i] = 1;
            wait_drain(i);
        end

        // Wide frame, then reset in the middle of the next one.
        send_frame(2, 9'h1AB, 1'b0, 2'b11, -1, 1, 1'b1);
        wait_drain(2);
        part = 16'b0000_0000_0000_1010;  // start bit, then data bits 1,0,1
        for (int n = 0; n < 4; n++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                rxp[2] = part[n];
            end
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rxp[2] = 1'b0;
        end
        check(2, "busy_mid_frame", 32'(bsy[2]), 1);
        rst    = 1'b1;
        rxp[2] = 1'b1;
        @(negedge clk);
        check(2, "midrst_valid", 32'(vld[2]), 0);
        check(2, "midrst_data",  32'(d2), 0);
        check(2, "midrst_perr",  32'(pe[2]), 0);
        check(2, "midrst_ferr",  32'(fe[2]), 0);
        check(2, "midrst_busy",  32'(bsy[2]), 0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        send_frame(2, 9'($urandom), 1'($urandom_range(0, 1)), 2'b11, -1, 1, 1'b1);
        wait_drain(2);

        check(0, "overrun_total", 32'(ovr_cnt[0]), 1);
        check(1, "overrun_total", 32'(ovr_cnt[1]), 0);
        check(2, "overrun_total", 32'(ovr_cnt[2]), 0);
        for (int i = 0; i < 3; i++) check(i, "final_queue", 32'(qsize(i)), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
